// File: rtl/axis_tap_arb_if.sv
// Bundle of the tapped links, their grant mask and the mirror output.
// Latency: n/a (wiring only).
// Backpressure: m_axis_tready is the only ready driven towards the arbiter.
interface axis_tap_arb_if #(
  parameter int S_COUNT    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
);
  localparam int ID_WIDTH = $clog2(S_COUNT);

  // Passively monitored links, link i in slice i
  logic [S_COUNT*DATA_WIDTH-1:0] tap_axis_tdata;
  logic [S_COUNT*KEEP_WIDTH-1:0] tap_axis_tkeep;
  logic [S_COUNT-1:0]            tap_axis_tvalid;
  logic [S_COUNT-1:0]            tap_axis_tready;
  logic [S_COUNT-1:0]            tap_axis_tlast;
  logic [S_COUNT*DEST_WIDTH-1:0] tap_axis_tdest;
  logic [S_COUNT*USER_WIDTH-1:0] tap_axis_tuser;
  logic [S_COUNT-1:0]            tap_enable;

  // Mirror output
  logic [DATA_WIDTH-1:0]         m_axis_tdata;
  logic [KEEP_WIDTH-1:0]         m_axis_tkeep;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;
  logic                          m_axis_tlast;
  logic [ID_WIDTH-1:0]           m_axis_tid;
  logic [DEST_WIDTH-1:0]         m_axis_tdest;
  logic [USER_WIDTH-1:0]         m_axis_tuser;

  // Environment side: drives the taps and the output ready
  modport master (
    output tap_axis_tdata, tap_axis_tkeep, tap_axis_tvalid, tap_axis_tready,
           tap_axis_tlast, tap_axis_tdest, tap_axis_tuser, tap_enable,
           m_axis_tready,
    input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
           m_axis_tid, m_axis_tdest, m_axis_tuser
  );

  // Arbiter side: observes the taps, drives the mirror output
  modport slave (
    input  tap_axis_tdata, tap_axis_tkeep, tap_axis_tvalid, tap_axis_tready,
           tap_axis_tlast, tap_axis_tdest, tap_axis_tuser, tap_enable,
           m_axis_tready,
    output m_axis_tdata, m_axis_tkeep, m_axis_tvalid, m_axis_tlast,
           m_axis_tid, m_axis_tdest, m_axis_tuser
  );
endinterface

// File: rtl/axis_tap_arb.sv
// Frame-level round-robin mirror of S_COUNT tapped AXI-stream links onto one output.
// Latency: 1 cycle from tapped beat to m_axis_tvalid; optional stats via AXIS_TAP_ARB_STATS_EN.
// Backpressure: never stalls the taps; output overflow truncates the frame with a bad-frame terminator.
module axis_tap_arb #(
  parameter int                    S_COUNT              = 4,
  parameter int                    DATA_WIDTH           = 64,
  parameter bit                    KEEP_ENABLE          = (DATA_WIDTH > 8),
  parameter int                    KEEP_WIDTH           = DATA_WIDTH / 8,
  parameter bit                    DEST_ENABLE          = 1'b1,
  parameter int                    DEST_WIDTH           = 8,
  parameter int                    USER_WIDTH           = 1,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  axis_tap_arb_if.slave      bus,
  output logic               busy
`ifdef AXIS_TAP_ARB_STATS_EN
  ,
  output logic [31:0]        stat_frames,
  output logic [31:0]        stat_drops
`endif
);
  localparam int ID_WIDTH = $clog2(S_COUNT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;
  localparam logic [1:0] ST_SKIP = 2'd3;

  // Control state
  logic [1:0]            state_q, state_d;
  logic [ID_WIDTH-1:0]   grant_q, grant_d;
  logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic                  last_seen_q, last_seen_d;
  logic [S_COUNT-1:0]    in_frame_q, in_frame_d;

  // Output register
  logic [DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [KEEP_WIDTH-1:0] m_tkeep_q, m_tkeep_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic                  m_tlast_q, m_tlast_d;
  logic [ID_WIDTH-1:0]   m_tid_q, m_tid_d;
  logic [DEST_WIDTH-1:0] m_tdest_q, m_tdest_d;
  logic [USER_WIDTH-1:0] m_tuser_q, m_tuser_d;

  // Combinational helpers
  logic [S_COUNT-1:0]    beat;
  logic [S_COUNT-1:0]    elig;
  logic                  can_load;
  logic [ID_WIDTH-1:0]   sel;
  logic                  sel_found;
  logic [ID_WIDTH-1:0]   src;
  logic [DATA_WIDTH-1:0] src_tdata;
  logic [KEEP_WIDTH-1:0] src_tkeep;
  logic [DEST_WIDTH-1:0] src_tdest;
  logic [USER_WIDTH-1:0] src_tuser;
  logic                  src_beat;
  logic                  src_last;
  logic                  load_beat;
  logic                  load_term;
  logic                  drop_evt;

  assign beat     = bus.tap_axis_tvalid & bus.tap_axis_tready;
  assign elig     = beat & ~in_frame_q & bus.tap_enable;
  assign can_load = ~m_tvalid_q | bus.m_axis_tready;

  // Frame tracking per link: a beat opens a frame unless it is the last one
  always_comb begin
    in_frame_d = (in_frame_q & ~beat) | (beat & ~bus.tap_axis_tlast);
  end

  // Round-robin pick: first eligible link at or after rr_ptr, with wrap
  always_comb begin
    logic [ID_WIDTH:0]   wrap_sum;
    logic [ID_WIDTH-1:0] cand;
    sel       = '0;
    sel_found = 1'b0;
    wrap_sum  = '0;
    cand      = '0;
    for (int k = 0; k < S_COUNT; k++) begin
      wrap_sum = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(k);
      if (wrap_sum >= (ID_WIDTH+1)'(S_COUNT)) begin
        wrap_sum = wrap_sum - (ID_WIDTH+1)'(S_COUNT);
      end
      cand = wrap_sum[ID_WIDTH-1:0];
      if (!sel_found && elig[cand]) begin
        sel_found = 1'b1;
        sel       = cand;
      end
    end
  end

  // Source link mux: the candidate while idle, the granted link otherwise
  always_comb begin
    src       = (state_q == ST_IDLE) ? sel : grant_q;
    src_tdata = bus.tap_axis_tdata[int'(src)*DATA_WIDTH +: DATA_WIDTH];
    src_tkeep = bus.tap_axis_tkeep[int'(src)*KEEP_WIDTH +: KEEP_WIDTH];
    src_tdest = bus.tap_axis_tdest[int'(src)*DEST_WIDTH +: DEST_WIDTH];
    src_tuser = bus.tap_axis_tuser[int'(src)*USER_WIDTH +: USER_WIDTH];
    src_beat  = beat[src];
    src_last  = bus.tap_axis_tlast[src];
  end

  // Grant state machine and output register next-state
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    last_seen_d = last_seen_q;
    load_beat   = 1'b0;
    load_term   = 1'b0;
    drop_evt    = 1'b0;

    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tvalid_d = m_tvalid_q & ~bus.m_axis_tready;
    m_tlast_d  = m_tlast_q;
    m_tid_d    = m_tid_q;
    m_tdest_d  = m_tdest_q;
    m_tuser_d  = m_tuser_q;

    case (state_q)
      ST_IDLE: begin
        // Frames that start while the output is full are never granted
        if (sel_found && can_load) begin
          grant_d   = sel;
          rr_ptr_d  = (sel == ID_WIDTH'(S_COUNT-1)) ? '0 : sel + ID_WIDTH'(1);
          load_beat = 1'b1;
          if (!src_last) state_d = ST_PASS;
        end
      end
      ST_PASS: begin
        if (src_beat) begin
          if (can_load) begin
            load_beat = 1'b1;
            if (src_last) state_d = ST_IDLE;
          end else begin
            state_d     = ST_DROP;
            last_seen_d = src_last;
            drop_evt    = 1'b1;
          end
        end
      end
      ST_DROP: begin
        // Include a same-cycle tlast so a terminator on the final beat
        // does not leave us waiting in SKIP for a frame end already seen
        last_seen_d = last_seen_q | (src_beat & src_last);
        if (can_load) begin
          load_term = 1'b1;
          state_d   = last_seen_d ? ST_IDLE : ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (src_beat && src_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_beat) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = src_tdata;
      m_tkeep_d  = KEEP_ENABLE ? src_tkeep : '1;
      m_tlast_d  = src_last;
      m_tid_d    = src;
      m_tdest_d  = DEST_ENABLE ? src_tdest : '0;
      m_tuser_d  = src_tuser;
    end else if (load_term) begin
      m_tvalid_d = 1'b1;
      m_tdata_d  = '0;
      m_tkeep_d  = KEEP_WIDTH'(1);
      m_tlast_d  = 1'b1;
      m_tid_d    = grant_q;
      m_tdest_d  = '0;
      m_tuser_d  = USER_BAD_FRAME_VALUE;
    end
  end

  // Control and output registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      last_seen_q <= 1'b0;
      in_frame_q  <= '0;
      m_tdata_q   <= '0;
      m_tkeep_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tid_q     <= '0;
      m_tdest_q   <= '0;
      m_tuser_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      last_seen_q <= last_seen_d;
      in_frame_q  <= in_frame_d;
      m_tdata_q   <= m_tdata_d;
      m_tkeep_q   <= m_tkeep_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tlast_q   <= m_tlast_d;
      m_tid_q     <= m_tid_d;
      m_tdest_q   <= m_tdest_d;
      m_tuser_q   <= m_tuser_d;
    end
  end

  assign bus.m_axis_tdata  = m_tdata_q;
  assign bus.m_axis_tkeep  = m_tkeep_q;
  assign bus.m_axis_tvalid = m_tvalid_q;
  assign bus.m_axis_tlast  = m_tlast_q;
  assign bus.m_axis_tid    = m_tid_q;
  assign bus.m_axis_tdest  = m_tdest_q;
  assign bus.m_axis_tuser  = m_tuser_q;
  assign busy              = (state_q != ST_IDLE);

`ifdef AXIS_TAP_ARB_STATS_EN
  logic [31:0] stat_frames_q, stat_frames_d;
  logic [31:0] stat_drops_q, stat_drops_d;

  // Count frames leaving the mirror (including terminators) and truncations
  always_comb begin
    stat_frames_d = stat_frames_q
                  + {31'd0, m_tvalid_q & bus.m_axis_tready & m_tlast_q};
    stat_drops_d  = stat_drops_q + {31'd0, drop_evt};
  end

  // Statistics counters, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_frames_q <= '0;
      stat_drops_q  <= '0;
    end else begin
      stat_frames_q <= stat_frames_d;
      stat_drops_q  <= stat_drops_d;
    end
  end

  assign stat_frames = stat_frames_q;
  assign stat_drops  = stat_drops_q;
`endif

endmodule

// File: tb/tb_axis_tap_arb.sv
// Directed bench for axis_tap_arb: round-robin grant, truncation, masking, reset.
// Latency: checks outputs #1 after the edge that loads them.
// Backpressure: exercises m_axis_tready low to force a terminator.
module tb_axis_tap_arb;
  logic clk;
  logic rst;
  logic busy;
  int   n_tests;
  int   n_fail;
`ifdef AXIS_TAP_ARB_STATS_EN
  logic [31:0] stat_frames;
  logic [31:0] stat_drops;
`endif

  axis_tap_arb_if #(
    .S_COUNT(4), .DATA_WIDTH(64), .KEEP_WIDTH(8), .DEST_WIDTH(8), .USER_WIDTH(1)
  ) bus ();

  axis_tap_arb #(
    .S_COUNT(4), .DATA_WIDTH(64), .KEEP_ENABLE(1'b1), .KEEP_WIDTH(8),
    .DEST_ENABLE(1'b1), .DEST_WIDTH(8), .USER_WIDTH(1), .USER_BAD_FRAME_VALUE(1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
`ifdef AXIS_TAP_ARB_STATS_EN
    ,
    .stat_frames (stat_frames),
    .stat_drops  (stat_drops)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.tap_axis_tvalid = '0;
    bus.tap_axis_tlast  = '0;
  endtask

  task automatic beat_on(input int l, input logic [63:0] d, input logic last);
    bus.tap_axis_tvalid[l]          = 1'b1;
    bus.tap_axis_tdata[l*64 +: 64]  = d;
    bus.tap_axis_tkeep[l*8 +: 8]    = 8'hFF;
    bus.tap_axis_tlast[l]           = last;
    bus.tap_axis_tdest[l*8 +: 8]    = 8'(8'h10 + l);
    bus.tap_axis_tuser[l]           = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input logic [63:0] d, input logic last,
                          input int id);
    check({tag, ".vld"},  64'(bus.m_axis_tvalid), 64'd1);
    check({tag, ".data"}, bus.m_axis_tdata, d);
    check({tag, ".last"}, 64'(bus.m_axis_tlast), 64'(last));
    check({tag, ".tid"},  64'(bus.m_axis_tid), 64'(id));
  endtask

  task automatic pulse_rst();
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.tap_axis_tdata  = '0;
    bus.tap_axis_tkeep  = '0;
    bus.tap_axis_tvalid = '0;
    bus.tap_axis_tready = '1;
    bus.tap_axis_tlast  = '0;
    bus.tap_axis_tdest  = '0;
    bus.tap_axis_tuser  = '0;
    bus.tap_enable      = 4'b1111;
    bus.m_axis_tready   = 1'b1;
    tick();
    tick();
    check("rst.vld",  64'(bus.m_axis_tvalid), 64'd0);
    check("rst.last", 64'(bus.m_axis_tlast), 64'd0);
    check("rst.data", bus.m_axis_tdata, 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    rst = 1'b0;

    // 1: three-beat frame on link 2
    clr(); beat_on(2, 64'hD0, 1'b0); tick();
    chk_beat("t1.b0", 64'hD0, 1'b0, 2);
    check("t1.tdest", 64'(bus.m_axis_tdest), 64'h12);
    check("t1.tuser", 64'(bus.m_axis_tuser), 64'd0);
    check("t1.tkeep", 64'(bus.m_axis_tkeep), 64'hFF);
    check("t1.busy0", 64'(busy), 64'd1);
    clr(); beat_on(2, 64'hD1, 1'b0); tick();
    chk_beat("t1.b1", 64'hD1, 1'b0, 2);
    clr(); beat_on(2, 64'hD2, 1'b1); tick();
    chk_beat("t1.b2", 64'hD2, 1'b1, 2);
    check("t1.busy2", 64'(busy), 64'd0);
    clr(); tick();
    check("t1.vld_off", 64'(bus.m_axis_tvalid), 64'd0);

    // 2: simultaneous starts on links 0 and 1, twice
    pulse_rst();
    clr(); beat_on(0, 64'hA0, 1'b0); beat_on(1, 64'hB0, 1'b0); tick();
    chk_beat("t2.a0", 64'hA0, 1'b0, 0);
    clr(); beat_on(0, 64'hA1, 1'b1); beat_on(1, 64'hB1, 1'b1); tick();
    chk_beat("t2.a1", 64'hA1, 1'b1, 0);
    clr(); beat_on(0, 64'hA2, 1'b0); beat_on(1, 64'hB2, 1'b0); tick();
    chk_beat("t2.b2", 64'hB2, 1'b0, 1);
    clr(); beat_on(0, 64'hA3, 1'b1); beat_on(1, 64'hB3, 1'b1); tick();
    chk_beat("t2.b3", 64'hB3, 1'b1, 1);
    clr(); tick();
    check("t2.rr_ptr", 64'(dut.rr_ptr_q), 64'd2);

    // 3: output stalls after the first beat of a 5-beat frame on link 0
    pulse_rst();
    clr(); beat_on(0, 64'hC0, 1'b0); tick();
    chk_beat("t3.c0", 64'hC0, 1'b0, 0);
    bus.m_axis_tready = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      clr(); beat_on(0, 64'(64'hC0 + b), (b == 4)); tick();
    end
    chk_beat("t3.hold", 64'hC0, 1'b0, 0);
    check("t3.busy_drop", 64'(busy), 64'd1);
    clr(); bus.m_axis_tready = 1'b1; tick();
    chk_beat("t3.term", 64'd0, 1'b1, 0);
    check("t3.term_user", 64'(bus.m_axis_tuser), 64'd1);
    check("t3.term_keep", 64'(bus.m_axis_tkeep), 64'd1);
    check("t3.busy_end", 64'(busy), 64'd0);
    tick();
    check("t3.vld_off", 64'(bus.m_axis_tvalid), 64'd0);
`ifdef AXIS_TAP_ARB_STATS_EN
    check("t3.stat_drops",  64'(stat_drops), 64'd1);
    check("t3.stat_frames", 64'(stat_frames), 64'd1);
`endif

    // 4: masked link 3 ignored; unmasking withdrawn mid-frame on link 1
    bus.tap_enable = 4'b0111;
    clr(); beat_on(3, 64'hE0, 1'b0); tick();
    check("t4.masked0", 64'(bus.m_axis_tvalid), 64'd0);
    clr(); beat_on(3, 64'hE1, 1'b1); tick();
    check("t4.masked1", 64'(bus.m_axis_tvalid), 64'd0);
    clr(); beat_on(1, 64'hF0, 1'b0); tick();
    chk_beat("t4.f0", 64'hF0, 1'b0, 1);
    bus.tap_enable = 4'b0000;
    clr(); beat_on(1, 64'hF1, 1'b0); tick();
    chk_beat("t4.f1", 64'hF1, 1'b0, 1);
    clr(); beat_on(1, 64'hF2, 1'b1); tick();
    chk_beat("t4.f2", 64'hF2, 1'b1, 1);
    bus.tap_enable = 4'b1111;

    // 5: reset during beat 2 of a frame on link 1
    clr(); beat_on(1, 64'h60, 1'b0); tick();
    chk_beat("t5.g0", 64'h60, 1'b0, 1);
    clr(); beat_on(1, 64'h61, 1'b0); tick();
    clr(); beat_on(1, 64'h62, 1'b0); rst = 1'b1; tick();
    rst = 1'b0;
    check("t5.vld_rst",  64'(bus.m_axis_tvalid), 64'd0);
    check("t5.busy_rst", 64'(busy), 64'd0);
    clr(); beat_on(2, 64'h70, 1'b0); tick();
    chk_beat("t5.h0", 64'h70, 1'b0, 2);
    clr(); beat_on(2, 64'h71, 1'b1); tick();
    chk_beat("t5.h1", 64'h71, 1'b1, 2);
    clr(); tick();

    // 6: back-to-back single-beat frames on link 3
    for (int i = 0; i < 4; i++) begin
      clr(); beat_on(3, 64'(64'h80 + i), 1'b1); tick();
      chk_beat("t6.k", 64'(64'h80 + i), 1'b1, 3);
      check("t6.busy", 64'(busy), 64'd0);
    end
    clr(); tick();
    check("t6.vld_off", 64'(bus.m_axis_tvalid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
